// File: rtl/alu_iter.sv
// Registered MIPS ALU with iterative multiply/divide driving HI/LO.
// Single-cycle ops complete in one edge; mult/div take WIDTH+1 edges behind busy.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             ov_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             ov,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             zero_q, zero_d;
  logic             ov_q, ov_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  // Handshake: start is taken only while IDLE (busy low); a taken request
  // yields exactly one done pulse, and start during busy is dropped.
  logic accept, long_op, div_op, signed_op, b_zero, go_long;
  assign accept    = (state_q == S_IDLE) && start;
  assign long_op   = (op[3:2] == 2'b10);
  assign div_op    = op[1];
  assign signed_op = ~op[0];
  assign b_zero    = (b_in == '0);
  assign go_long   = accept && long_op && !(div_op && b_zero);

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = signed_op & a_in[WIDTH-1];
  assign b_neg = signed_op & b_in[WIDTH-1];
  assign a_mag = a_neg ? -a_in : a_in;
  assign b_mag = b_neg ? -b_in : b_in;

  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             add_ov, sub_ov, alu_ov;
  assign sum    = a_in + b_in;
  assign diff   = a_in - b_in;
  assign add_ov = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != a_in[WIDTH-1]);
  assign sub_ov = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (diff[WIDTH-1] != a_in[WIDTH-1]);

  always_comb begin
    alu_res = '0;
    alu_ov  = 1'b0;
    case (op)
      4'b0000: begin alu_res = sum;  alu_ov = ov_en & add_ov; end
      4'b0001: begin alu_res = diff; alu_ov = ov_en & sub_ov; end
      4'b0010: alu_res = a_in | b_in;
      4'b0011: alu_res = a_in & b_in;
      4'b0100: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
      4'b0101: alu_res = {{(WIDTH-1){1'b0}}, (a_in < b_in)};
      4'b0110: alu_res = a_in ^ b_in;
      4'b0111: alu_res = ~(a_in | b_in);
      default: alu_res = '0;
    endcase
  end

  // Multiply: multiplier shifts out of acc_lo while the partial product
  // shifts into it. Divide: dividend shifts from acc_lo into the remainder.
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] rem_sub, rem_nx;
  logic             rem_ge;
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
  assign rem_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign rem_ge  = (rem_sh >= {1'b0, opb_q});
  assign rem_sub = rem_sh[WIDTH-1:0] - opb_q;
  assign rem_nx  = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];

  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_lo_q ? -prod : prod;
  assign fix_hi   = is_div_q ? (neg_hi_q ? -acc_hi_q : acc_hi_q) : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_lo   = is_div_q ? (neg_lo_q ? -acc_lo_q : acc_lo_q) : prod_fix[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (go_long) state_d = S_CALC;
      S_CALC:  if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opb_d    = opb_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    zero_d   = zero_q;
    ov_d     = ov_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go_long) begin
          acc_hi_d = '0;
          acc_lo_d = a_mag;
          opb_d    = b_mag;
          is_div_d = div_op;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          cnt_d    = CW'(WIDTH);
        end else if (accept && long_op) begin
          lo_d     = '1;
          hi_d     = a_in;
          result_d = '1;
          zero_d   = 1'b0;
          ov_d     = 1'b0;
          dbz_d    = 1'b1;
          done_d   = 1'b1;
        end else if (accept) begin
          result_d = alu_res;
          zero_d   = (alu_res == '0);
          ov_d     = alu_ov;
          dbz_d    = 1'b0;
          done_d   = 1'b1;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          acc_hi_d = rem_nx;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], rem_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        hi_d     = fix_hi;
        lo_d     = fix_lo;
        result_d = fix_lo;
        zero_d   = (fix_lo == '0);
        ov_d     = 1'b0;
        dbz_d    = 1'b0;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opb_q    <= '0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      zero_q   <= 1'b1;
      ov_q     <= 1'b0;
      dbz_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      zero_q   <= zero_d;
      ov_q     <= ov_d;
      dbz_q    <= dbz_d;
      done_q   <= done_d;
    end
  end

  assign done        = done_q;
  assign result      = result_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign zero        = zero_q;
  assign ov          = ov_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: directed literal cases plus randomized traffic checked
// every cycle against a timeline model built on 64-bit arithmetic.
module tb_alu_iter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         ov_en = 1'b0;
  logic         busy, done, zero, ov, div_by_zero;
  logic [W-1:0] result, hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  alu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .ov_en(ov_en), .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo),
    .zero(zero), .ov(ov), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0] result, hi, lo;
    logic         zero, ov, dbz, long_op;
  } res_t;

  function automatic res_t model_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic oe, input logic [W-1:0] cur_hi, input logic [W-1:0] cur_lo);
    res_t r;
    logic signed [63:0] sa, sb, sr, sq;
    logic [63:0] ua, ub, ur;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    r.hi = cur_hi; r.lo = cur_lo; r.ov = 1'b0; r.dbz = 1'b0; r.long_op = 1'b0; r.result = '0;
    case (o)
      4'd0: begin sr = sa + sb; r.result = sr[31:0];
                  r.ov = oe && (sr > 64'sd2147483647 || sr < -64'sd2147483648); end
      4'd1: begin sr = sa - sb; r.result = sr[31:0];
                  r.ov = oe && (sr > 64'sd2147483647 || sr < -64'sd2147483648); end
      4'd2: r.result = a | b;
      4'd3: r.result = a & b;
      4'd4: r.result = (sa < sb) ? 32'd1 : 32'd0;
      4'd5: r.result = (ua < ub) ? 32'd1 : 32'd0;
      4'd6: r.result = a ^ b;
      4'd7: r.result = ~(a | b);
      4'd8: begin sr = sa * sb; r.hi = sr[63:32]; r.lo = sr[31:0]; r.long_op = 1'b1; end
      4'd9: begin ur = ua * ub; r.hi = ur[63:32]; r.lo = ur[31:0]; r.long_op = 1'b1; end
      4'd10, 4'd11: begin
        if (b == 0) begin
          r.hi = a; r.lo = '1; r.dbz = 1'b1;
        end else if (o == 4'd10) begin
          sq = sa / sb; sr = sa % sb;
          r.lo = sq[31:0]; r.hi = sr[31:0]; r.long_op = 1'b1;
        end else begin
          ur = ua / ub; r.lo = ur[31:0];
          ur = ua % ub; r.hi = ur[31:0]; r.long_op = 1'b1;
        end
        r.result = r.lo;
      end
      default: r.result = '0;
    endcase
    if (o[3:2] == 2'b10) r.result = r.lo;
    r.zero = (r.result == 0);
    return r;
  endfunction

  logic [W-1:0] exp_result = '0, exp_hi = '0, exp_lo = '0;
  logic         exp_zero = 1'b1, exp_ov = 1'b0, exp_dbz = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
  bit           pend = 1'b0;
  int           remain = 0;
  res_t         pend_res;

  always @(posedge clk or posedge rst) begin
    res_t r;
    if (rst) begin
      exp_result = '0; exp_hi = '0; exp_lo = '0; exp_zero = 1'b1; exp_ov = 1'b0;
      exp_dbz = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; pend = 1'b0; remain = 0;
    end else begin
      exp_done = 1'b0;
      if (pend) begin
        remain--;
        if (remain == 0) begin
          exp_result = pend_res.result; exp_hi = pend_res.hi; exp_lo = pend_res.lo;
          exp_zero = pend_res.zero; exp_ov = pend_res.ov; exp_dbz = pend_res.dbz;
          exp_done = 1'b1; exp_busy = 1'b0; pend = 1'b0;
        end
      end else if (start) begin
        r = model_op(op, a_in, b_in, ov_en, exp_hi, exp_lo);
        if (r.long_op) begin
          pend = 1'b1; remain = W + 1; pend_res = r; exp_busy = 1'b1;
        end else begin
          exp_result = r.result; exp_hi = r.hi; exp_lo = r.lo;
          exp_zero = r.zero; exp_ov = r.ov; exp_dbz = r.dbz; exp_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", busy, exp_busy);
      check("cyc_done", done, exp_done);
      check("cyc_result", result, exp_result);
      check("cyc_hi", hi, exp_hi);
      check("cyc_lo", lo, exp_lo);
      check("cyc_zero", zero, exp_zero);
      check("cyc_ov", ov, exp_ov);
      check("cyc_dbz", div_by_zero, exp_dbz);
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic oe);
    start = 1'b1; op = o; a_in = a; b_in = b; ov_en = oe;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int busy_cyc);
    n = 0; busy_cyc = 0;
    while (!done && n < 100) begin
      busy_cyc += int'(busy);
      @(posedge clk); #2;
      n++;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done: no done pulse within 100 cycles at %0t", $time);
    end
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int n, bc;
    bit seen_done;
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;
    #4;
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    rst = 1'b0;
    @(posedge clk); #2;

    issue(4'd0, 32'h7FFFFFFF, 32'h1, 1'b1); wait_done(n, bc);
    check("add_lat", n, 0);
    check("add_result", result, 32'h80000000);
    check("add_ov", ov, 1);
    check("add_zero", zero, 0);
    issue(4'd0, 32'h7FFFFFFF, 32'h1, 1'b0); wait_done(n, bc);
    check("add_noov", ov, 0);
    issue(4'd1, 32'd5, 32'd5, 1'b1); wait_done(n, bc);
    check("sub_result", result, 0);
    check("sub_zero", zero, 1);

    issue(4'd8, 32'hFFFFFFFD, 32'd5, 1'b0); wait_done(n, bc);
    check("mult_lat", n, W + 1);
    check("mult_busy_cycles", bc, W + 1);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFF1);
    check("mult_result", result, 32'hFFFFFFF1);

    issue(4'd4, 32'hFFFFFFFF, 32'd1, 1'b0); wait_done(n, bc);
    check("slt_result", result, 1);
    check("slt_hi_kept", hi, 32'hFFFFFFFF);
    check("slt_lo_kept", lo, 32'hFFFFFFF1);
    issue(4'd5, 32'hFFFFFFFF, 32'd1, 1'b0); wait_done(n, bc);
    check("sltu_result", result, 0);
    issue(4'd7, 32'd0, 32'd0, 1'b0); wait_done(n, bc);
    check("nor_result", result, 32'hFFFFFFFF);

    issue(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0); wait_done(n, bc);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    issue(4'd10, 32'hFFFFFFF9, 32'd2, 1'b0); wait_done(n, bc);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    issue(4'd11, 32'd7, 32'd0, 1'b0); wait_done(n, bc);
    check("dbz_lat", n, 0);
    check("dbz_flag", div_by_zero, 1);
    check("dbz_lo", lo, 32'hFFFFFFFF);
    check("dbz_hi", hi, 32'd7);
    issue(4'd10, 32'h80000000, 32'hFFFFFFFF, 1'b0); wait_done(n, bc);
    check("divmin_lo", lo, 32'h80000000);
    check("divmin_hi", hi, 0);
    check("divmin_dbz", div_by_zero, 0);

    issue(4'd8, 32'h00010000, 32'h00030000, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    issue(4'd0, 32'($urandom), 32'($urandom), 1'b1);
    a_in = 32'($urandom); b_in = 32'($urandom);
    wait_done(n, bc);
    check("intf_hi", hi, 32'd3);
    check("intf_lo", lo, 32'd0);
    check("intf_zero", zero, 1);
    issue(4'd0, 32'd2, 32'd3, 1'b0); wait_done(n, bc);
    check("donecyc_lat", n, 0);
    check("donecyc_result", result, 32'd5);

    issue(4'd8, 32'h00001234, 32'h00005678, 1'b0);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_done", done, 0);
    #2 rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", seen_done, 0);
    issue(4'd11, 32'd100, 32'd7, 1'b0); wait_done(n, bc);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) != 0);
      op    = 4'($urandom_range(0, 15));
      a_in  = rand_val();
      b_in  = rand_val();
      ov_en = 1'($urandom_range(0, 1));
      @(posedge clk); #2;
    end
    start = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
